param_johnson_counter: RTL and testbench

PARAM_JOHNSON_COUNTER -- requirements
Module: param_johnson_counter

---
 rtl/param_johnson_counter.sv | 120 ++++++++++++
 tb/tb_param_johnson_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/param_johnson_counter.sv
// Parameterised up/down Johnson counter with load, forward index and wrap/illegal pulses.
// Define JOHNSON_SELF_CORRECT_EN to steer illegal loads and illegal states back to all-zeros.
module param_johnson_counter #(
   parameter int WIDTH = 4,
   parameter int IDXW  = $clog2(2*WIDTH)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             Up_down,
   input  logic             Load,
   input  logic [WIDTH-1:0] Load_value,
   output logic [WIDTH-1:0] Count_out,
   output logic [IDXW-1:0]  State_index,
   output logic             Wrap,
   output logic             Illegal
);

   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] LSB_ONLY = WIDTH'(1);
   localparam logic [WIDTH-2:0] EDGE_ONE = (WIDTH-1)'(1);

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;
   logic             wrap_reg;
   logic             wrap_next;
   logic             illegal_reg;
   logic             illegal_next;
   logic [WIDTH-2:0] count_edges;
   logic             count_legal;
   int               pop;

   // A legal Johnson state has at most one adjacent-bit transition.
   for (genvar gi = 0; gi < WIDTH-1; gi++) begin : g_count_edges
      assign count_edges[gi] = count_reg[gi+1] ^ count_reg[gi];
   end
   assign count_legal = ((count_edges & (count_edges - EDGE_ONE)) == '0);

`ifdef JOHNSON_SELF_CORRECT_EN
   logic [WIDTH-2:0] load_edges;
   logic             load_legal;

   for (genvar gi = 0; gi < WIDTH-1; gi++) begin : g_load_edges
      assign load_edges[gi] = Load_value[gi+1] ^ Load_value[gi];
   end
   assign load_legal = ((load_edges & (load_edges - EDGE_ONE)) == '0);
`endif

   always_comb begin
      pop = 0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + int'(count_reg[i]);
      end
      State_index = '0;
      if (count_legal) begin
         if (count_reg[WIDTH-1]) begin
            State_index = IDXW'(2*WIDTH - pop);
         end else begin
            State_index = IDXW'(pop);
         end
      end
   end

   always_comb begin
      count_next   = count_reg;
      wrap_next    = 1'b0;
      illegal_next = 1'b0;
      if (Load) begin
`ifdef JOHNSON_SELF_CORRECT_EN
         if (load_legal) begin
            count_next = Load_value;
         end else begin
            count_next   = '0;
            illegal_next = 1'b1;
         end
`else
         count_next = Load_value;
`endif
      end else if (Enable) begin
`ifdef JOHNSON_SELF_CORRECT_EN
         if (!count_legal) begin
            count_next   = '0;
            illegal_next = 1'b1;
         end else if (Up_down) begin
            count_next = {count_reg[WIDTH-2:0], ~count_reg[WIDTH-1]};
            wrap_next  = (count_reg == MSB_ONLY);
         end else begin
            count_next = {~count_reg[0], count_reg[WIDTH-1:1]};
            wrap_next  = (count_reg == LSB_ONLY);
         end
`else
         // Illegal states simply circulate; only 10..0 / 0..01 can step into zero.
         if (Up_down) begin
            count_next = {count_reg[WIDTH-2:0], ~count_reg[WIDTH-1]};
            wrap_next  = (count_reg == MSB_ONLY);
         end else begin
            count_next = {~count_reg[0], count_reg[WIDTH-1:1]};
            wrap_next  = (count_reg == LSB_ONLY);
         end
`endif
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         count_reg   <= '0;
         wrap_reg    <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         count_reg   <= count_next;
         wrap_reg    <= wrap_next;
         illegal_reg <= illegal_next;
      end
   end

   assign Count_out = count_reg;
   assign Wrap      = wrap_reg;
   assign Illegal   = illegal_reg;

endmodule

// File: tb/tb_param_johnson_counter.sv
// Scoreboard bench: three widths (2, 4, 8) driven in parallel against a sequence-table model.
module tb_param_johnson_counter;

`ifdef JOHNSON_SELF_CORRECT_EN
   localparam bit SELF_CORRECT = 1'b1;
`else
   localparam bit SELF_CORRECT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   for (genvar gi = 0; gi < 3; gi++) begin : g_w
      localparam int W  = (gi == 0) ? 2 : (gi == 1) ? 4 : 8;
      localparam int IX = $clog2(2*W);
      localparam int EW = W + IX + 2;

      logic         rst_n = 1'b0;
      logic         en    = 1'b0;
      logic         ud    = 1'b1;
      logic         ld    = 1'b0;
      logic [W-1:0] lv    = '0;
      logic [W-1:0] q;
      logic [IX-1:0] idx;
      logic         wrap;
      logic         ill;

      logic [EW-1:0] exp_q[$];
      logic [W-1:0]  seq[2*W];
      logic [W-1:0]  m_state = '0;
      bit            fin = 1'b0;

      param_johnson_counter #(.WIDTH(W)) dut (
         .Clock       (clk),
         .Reset       (rst_n),
         .Enable      (en),
         .Up_down     (ud),
         .Load        (ld),
         .Load_value  (lv),
         .Count_out   (q),
         .State_index (idx),
         .Wrap        (wrap),
         .Illegal     (ill)
      );

      function automatic int find_pos(input logic [W-1:0] v);
         for (int k = 0; k < 2*W; k++) begin
            if (seq[k] == v) return k;
         end
         return -1;
      endfunction

      // One clock of stimulus; the model's view of the following edge is queued.
      task automatic cycle(input logic r, input logic e, input logic u,
                           input logic l, input logic [W-1:0] v);
         int           k;
         logic         w_e;
         logic         i_e;
         logic [W-1:0] nxt;
         @(negedge clk);
         rst_n = r; en = e; ud = u; ld = l; lv = v;
         w_e = 1'b0;
         i_e = 1'b0;
         nxt = m_state;
         if (!r) begin
            nxt = '0;
         end else if (l) begin
            if (find_pos(v) < 0 && SELF_CORRECT) begin
               nxt = '0;
               i_e = 1'b1;
            end else begin
               nxt = v;
            end
         end else if (e) begin
            k = find_pos(m_state);
            if (k >= 0) begin
               k   = u ? (k + 1) % (2*W) : (k + 2*W - 1) % (2*W);
               nxt = seq[k];
               w_e = (k == 0);
            end else if (SELF_CORRECT) begin
               nxt = '0;
               i_e = 1'b1;
            end else begin
               nxt = u ? {m_state[W-2:0], ~m_state[W-1]} : {~m_state[0], m_state[W-1:1]};
            end
         end
         m_state = nxt;
         k = find_pos(nxt);
         exp_q.push_back({nxt, IX'((k < 0) ? 0 : k), w_e, i_e});
      endtask

      always @(posedge clk) begin : monitor
         logic [EW-1:0] e;
         logic [EW-1:0] a;
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {q, idx, wrap, ill};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL w=%0d q/idx/wrap/ill got %b/%0d/%b/%b exp %b/%0d/%b/%b", W,
                        a[EW-1 -: W], a[IX+1:2], a[1], a[0], e[EW-1 -: W], e[IX+1:2], e[1], e[0]);
            end else begin
               $display("w=%0d q=%b idx=%0d wrap=%b ill=%b", W, q, idx, wrap, ill);
            end
         end
      end

      initial begin : driver
         logic [W-1:0] alt;
         logic [W-1:0] v;
         logic [W-1:0] ones;
         for (int k = 0; k < 2*W; k++) begin
            if (k <= W) seq[k] = W'((64'd1 << k) - 64'd1);
            else        seq[k] = ~W'((64'd1 << (k - W)) - 64'd1);
         end
         for (int i = 0; i < W; i++) alt[i] = (i % 2 == 0);
         ones = '1;

         repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
         for (int i = 0; i < 2*W + 1; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
         for (int i = 0; i < W - 2; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
         repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
         repeat (5) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
         cycle(1'b1, 1'b0, 1'b1, 1'b1, seq[W+1]);
         cycle(1'b1, 1'b0, 1'b1, 1'b1, alt);
         repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
         cycle(1'b1, 1'b0, 1'b1, 1'b1, ones);
         cycle(1'b0, 1'b1, 1'b1, 1'b1, ones);
         cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
         cycle(1'b1, 1'b1, 1'b1, 1'b1, seq[1]);
         cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);

         for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 2) == 0) ? W'($urandom) : seq[$urandom_range(0, 2*W-1)];
            cycle($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, v);
         end
         cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);

         @(posedge clk);
         #3;
         total++;
         if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL w=%0d drain got %0d pending exp 0", W, exp_q.size());
         end
         fin = 1'b1;
      end
   end

   initial begin : supervisor
      int c;
      c = 0;
      while (!(g_w[0].fin && g_w[1].fin && g_w[2].fin) && c < 20000) begin
         @(posedge clk);
         c++;
      end
      if (c >= 20000) begin
         bad++;
         $display("FAIL timeout got %0d cycles exp completion", c);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
